// File: rtl/bcd_run_counter_pkg.sv
// Shared types and constants for the two-digit BCD run counter.
// Optional feature macro: BCD_CNT_DOWN_EN (enables the down-count direction).
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX = 4'd9;

    typedef enum logic {
        HOLD = 1'b0,
        RUN  = 1'b1
    } run_state_t;

    // True when a nibble is a legal BCD digit (0..9).
    function automatic logic isBcd(input bcd_t digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_run_counter_if.sv
// Control/status bundle of the BCD run counter. The master side drives the
// start/stop/direction/load controls; the slave side (the counter) returns
// the two digits and the status pulses.
interface bcd_run_counter_if;
    import bcd_pkg::*;

    logic       start;
    logic       stop;
    logic       up;
    logic       load;
    logic [7:0] load_val;
    bcd_t       ones;
    bcd_t       tens;
    logic       wrap;
    logic       load_err;
    logic       running;

    modport master (
        output start, stop, up, load, load_val,
        input  ones, tens, wrap, load_err, running
    );

    modport slave (
        input  start, stop, up, load, load_val,
        output ones, tens, wrap, load_err, running
    );

endinterface

// File: rtl/bcd_run_counter_digit.sv
// Single BCD digit register with load, increment and decrement.
// Increment past max rolls to 0 and raises carry; decrement below 0 rolls to
// max and raises borrow. Load has priority over counting.
// Optional feature macro: BCD_CNT_DOWN_EN (the top ties dec low when undefined).
module bcd_digit
    import bcd_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    input  logic load,
    input  bcd_t d,
    input  bcd_t max,
    output bcd_t q,
    output logic carry,
    output logic borrow
);

    bcd_t r_q;
    logic w_atMax;
    logic w_atZero;

    assign w_atMax  = (r_q == max);
    assign w_atZero = (r_q == 4'd0);
    assign carry    = inc && w_atMax;
    assign borrow   = dec && w_atZero;
    assign q        = r_q;

    // Digit register: reset, then load, then increment, then decrement.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= 4'd0;
        end else if (load) begin
            r_q <= d;
        end else if (inc) begin
            r_q <= w_atMax ? 4'd0 : r_q + 4'd1;
        end else if (dec) begin
            r_q <= w_atZero ? max : r_q - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_run_counter.sv
// Two-digit BCD run counter: prescaler, RUN/HOLD state machine, validated
// load, modulo wrap with a one-cycle wrap pulse.
// Optional feature macro: BCD_CNT_DOWN_EN. When defined the up input selects
// direction; when undefined the counter only counts up and up is ignored.
module bcd_run_counter
    import bcd_pkg::*;
#(
    parameter int DIV    = 50_000_000,
    parameter int MODULO = 100
)
(
    input logic         clk,
    input logic         rst_n,
    bcd_run_counter_if.slave bus
);

    localparam int            PRE_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam bcd_t          TOP_TENS   = bcd_t'((MODULO - 1) / 10);
    localparam bcd_t          TOP_ONES   = bcd_t'((MODULO - 1) % 10);
    localparam logic [6:0]    MOD_BIN    = 7'(MODULO);
    localparam bit            FULL_RANGE = (MODULO == 100);

    run_state_t       r_state;
    run_state_t       w_nextState;
    logic [PRE_W-1:0] r_prescale;
    logic             r_wrap;
    logic             r_loadErr;

    logic       w_tick;
    logic       w_up;
    logic       w_countEn;
    logic       w_loadOk;
    logic       w_atTop;
    logic       w_upWrapHit;
    logic       w_wrapNow;
    logic       w_digitLoad;
    logic       w_incOnes;
    logic       w_decOnes;
    logic       w_onesCarry;
    logic       w_onesBorrow;
    logic       w_tensCarry;
    logic       w_tensBorrow;
    bcd_t       w_ldOnes;
    bcd_t       w_ldTens;
    bcd_t       w_onesD;
    bcd_t       w_tensD;
    bcd_t       w_ones;
    bcd_t       w_tens;
    logic [6:0] w_loadBin;

    assign w_ldOnes  = bus.load_val[3:0];
    assign w_ldTens  = bus.load_val[7:4];
    assign w_loadBin = 7'(w_ldTens) * 7'd10 + 7'(w_ldOnes);
    assign w_loadOk  = isBcd(w_ldOnes) && isBcd(w_ldTens) && (w_loadBin < MOD_BIN);

    assign w_tick    = (r_state == RUN) && (r_prescale == PRE_LAST);
    assign w_countEn = w_tick && !bus.load;
    assign w_atTop   = (w_tens == TOP_TENS) && (w_ones == TOP_ONES);

    // With the full 00..99 range the tens carry-out is exactly the 99 -> 00 wrap.
    assign w_upWrapHit = FULL_RANGE ? w_tensCarry : w_atTop;

`ifdef BCD_CNT_DOWN_EN
    assign w_up      = bus.up;
    assign w_decOnes = w_countEn && !w_up;
    // Down wrap is the tens digit borrowing out of 00.
    assign w_wrapNow = w_countEn && (w_up ? w_upWrapHit : w_tensBorrow);
`else
    logic w_unusedDown;
    assign w_up         = 1'b1;
    assign w_decOnes    = 1'b0;
    assign w_wrapNow    = w_countEn && w_upWrapHit;
    assign w_unusedDown = bus.up | w_tensBorrow;
`endif

    assign w_incOnes   = w_countEn && w_up;
    assign w_digitLoad = (bus.load && w_loadOk) || w_wrapNow;

    // Digit load value: the external value on load, otherwise the wrap target.
    always_comb begin
        w_onesD = w_ldOnes;
        w_tensD = w_ldTens;
        if (!bus.load) begin
            w_onesD = 4'd0;
            w_tensD = 4'd0;
`ifdef BCD_CNT_DOWN_EN
            if (!w_up) begin
                w_onesD = TOP_ONES;
                w_tensD = TOP_TENS;
            end
`endif
        end
    end

    bcd_digit u_onesDigit (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (w_incOnes),
        .dec    (w_decOnes),
        .load   (w_digitLoad),
        .d      (w_onesD),
        .max    (BCD_MAX),
        .q      (w_ones),
        .carry  (w_onesCarry),
        .borrow (w_onesBorrow)
    );

    bcd_digit u_tensDigit (
        .clk    (clk),
        .rst_n  (rst_n),
        .inc    (w_onesCarry),
        .dec    (w_onesBorrow),
        .load   (w_digitLoad),
        .d      (w_tensD),
        .max    (BCD_MAX),
        .q      (w_tens),
        .carry  (w_tensCarry),
        .borrow (w_tensBorrow)
    );

    // RUN/HOLD state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= HOLD;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: stop beats start, from either state.
    always_comb begin
        w_nextState = r_state;
        if (bus.stop) begin
            w_nextState = HOLD;
        end else if (bus.start) begin
            w_nextState = RUN;
        end
    end

    // Prescaler: runs only in RUN, restarts on any load and after each tick.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prescale <= '0;
        end else if (bus.load || (r_state != RUN) || w_tick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + PRE_W'(1);
        end
    end

    // Registered status pulses, aligned with the count they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrap    <= 1'b0;
            r_loadErr <= 1'b0;
        end else begin
            r_wrap    <= w_wrapNow;
            r_loadErr <= bus.load && !w_loadOk;
        end
    end

    assign bus.ones     = w_ones;
    assign bus.tens     = w_tens;
    assign bus.wrap     = r_wrap;
    assign bus.load_err = r_loadErr;
    assign bus.running  = (r_state == RUN);

endmodule

// File: tb/tb_bcd_run_counter.sv
// Directed bench for bcd_run_counter. Two instances: A (DIV=1, MODULO=100)
// and B (DIV=4, MODULO=60). Expected values are hand-computed; where the
// down direction matters they depend on BCD_CNT_DOWN_EN.
`timescale 1ns/1ps
module tb_bcd_run_counter;
    import bcd_pkg::*;

`ifdef BCD_CNT_DOWN_EN
    localparam bit DOWN_EN = 1'b1;
`else
    localparam bit DOWN_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checkCount = 0;
    int   passCount  = 0;

    bcd_run_counter_if ifA ();
    bcd_run_counter_if ifB ();

    bcd_run_counter #(.DIV(1), .MODULO(100)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifA)
    );

    bcd_run_counter #(.DIV(4), .MODULO(60)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifB)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed 0x%02h, expected 0x%02h", tag, observed, expected);
        end
    endtask

    // Drive the controls of one instance (toB selects B, otherwise A).
    task automatic applyStimulus(input bit toB, input logic startV, input logic stopV,
                                 input logic upV, input logic loadV, input logic [7:0] loadValV);
        if (toB) begin
            ifB.start = startV; ifB.stop = stopV; ifB.up = upV;
            ifB.load = loadV;   ifB.load_val = loadValV;
        end else begin
            ifA.start = startV; ifA.stop = stopV; ifA.up = upV;
            ifA.load = loadV;   ifA.load_val = loadValV;
        end
    endtask

    // Advance n clock edges, leaving time 1 ns after the last edge.
    task automatic stepCycle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] cntA();
        return {ifA.tens, ifA.ones};
    endfunction

    function automatic logic [7:0] cntB();
        return {ifB.tens, ifB.ones};
    endfunction

    function automatic logic [7:0] flagsA();
        return {5'd0, ifA.running, ifA.wrap, ifA.load_err};
    endfunction

    function automatic logic [7:0] flagsB();
        return {5'd0, ifB.running, ifB.wrap, ifB.load_err};
    endfunction

    // Directed sequence; flags are packed {running, wrap, load_err}.
    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 0, 0, 1, 0, 8'h00);
        applyStimulus(1'b1, 0, 0, 1, 0, 8'h00);
        stepCycle(2);
        checkOutput("reset A count", cntA(), 8'h00);
        checkOutput("reset A flags", flagsA(), 8'h00);
        checkOutput("reset B count", cntB(), 8'h00);
        checkOutput("reset B flags", flagsB(), 8'h00);
        rst_n = 1'b1;

        // A: load 97 then run up through the 99 -> 00 wrap.
        applyStimulus(1'b0, 0, 0, 1, 1, 8'h97); stepCycle(1);
        checkOutput("A load97", cntA(), 8'h97);
        checkOutput("A load97 flags", flagsA(), 8'h00);
        applyStimulus(1'b0, 1, 0, 1, 0, 8'h00); stepCycle(1);
        checkOutput("A start count", cntA(), 8'h97);
        checkOutput("A start flags", flagsA(), 8'h04);
        applyStimulus(1'b0, 0, 0, 1, 0, 8'h00); stepCycle(1);
        checkOutput("A 98", cntA(), 8'h98);
        checkOutput("A 98 flags", flagsA(), 8'h04);
        stepCycle(1);
        checkOutput("A 99", cntA(), 8'h99);
        checkOutput("A 99 flags", flagsA(), 8'h04);
        stepCycle(1);
        checkOutput("A wrap 00", cntA(), 8'h00);
        checkOutput("A wrap flags", flagsA(), 8'h06);
        stepCycle(1);
        checkOutput("A 01", cntA(), 8'h01);
        checkOutput("A 01 flags", flagsA(), 8'h04);

        // A: stop, then start+stop from HOLD, then start alone.
        applyStimulus(1'b0, 0, 1, 1, 0, 8'h00); stepCycle(1);
        checkOutput("A stop count", cntA(), 8'h02);
        checkOutput("A stop flags", flagsA(), 8'h00);
        applyStimulus(1'b0, 0, 0, 1, 0, 8'h00); stepCycle(1);
        checkOutput("A hold frozen", cntA(), 8'h02);
        applyStimulus(1'b0, 1, 1, 1, 0, 8'h00); stepCycle(1);
        checkOutput("A both from HOLD", flagsA(), 8'h00);
        applyStimulus(1'b0, 0, 0, 1, 0, 8'h00); stepCycle(1);
        checkOutput("A both HOLD frozen", cntA(), 8'h02);
        applyStimulus(1'b0, 1, 0, 1, 0, 8'h00); stepCycle(1);
        checkOutput("A restart flags", flagsA(), 8'h04);
        checkOutput("A restart count", cntA(), 8'h02);
        applyStimulus(1'b0, 0, 0, 1, 0, 8'h00); stepCycle(1);
        checkOutput("A first tick", cntA(), 8'h03);

        // A: load while running beats the tick, then BCD carry 29 -> 30.
        applyStimulus(1'b0, 0, 0, 1, 1, 8'h29); stepCycle(1);
        checkOutput("A run load29", cntA(), 8'h29);
        applyStimulus(1'b0, 0, 0, 1, 0, 8'h00); stepCycle(1);
        checkOutput("A carry 30", cntA(), 8'h30);

        // A: start+stop while running -> HOLD, then frozen.
        applyStimulus(1'b0, 1, 1, 1, 0, 8'h00); stepCycle(1);
        checkOutput("A both from RUN flags", flagsA(), 8'h00);
        checkOutput("A both from RUN count", cntA(), 8'h31);
        applyStimulus(1'b0, 0, 0, 1, 0, 8'h00); stepCycle(1);
        checkOutput("A both RUN frozen", cntA(), 8'h31);

        // A: up=0 from 05, borrow at 10, wrap below 00 (up-only build keeps counting up).
        applyStimulus(1'b0, 0, 0, 0, 1, 8'h05); stepCycle(1);
        checkOutput("A load05", cntA(), 8'h05);
        applyStimulus(1'b0, 1, 0, 0, 0, 8'h00); stepCycle(1);
        checkOutput("A dir start", cntA(), 8'h05);
        applyStimulus(1'b0, 0, 0, 0, 0, 8'h00); stepCycle(1);
        checkOutput("A dir step1", cntA(), DOWN_EN ? 8'h04 : 8'h06);
        stepCycle(1);
        checkOutput("A dir step2", cntA(), DOWN_EN ? 8'h03 : 8'h07);
        applyStimulus(1'b0, 0, 0, 0, 1, 8'h10); stepCycle(1);
        checkOutput("A load10", cntA(), 8'h10);
        applyStimulus(1'b0, 0, 0, 0, 0, 8'h00); stepCycle(1);
        checkOutput("A borrow", cntA(), DOWN_EN ? 8'h09 : 8'h11);
        applyStimulus(1'b0, 0, 0, 0, 1, 8'h00); stepCycle(1);
        checkOutput("A load00", cntA(), 8'h00);
        applyStimulus(1'b0, 0, 0, 0, 0, 8'h00); stepCycle(1);
        checkOutput("A down wrap", cntA(), DOWN_EN ? 8'h99 : 8'h01);
        checkOutput("A down wrap flags", flagsA(), DOWN_EN ? 8'h06 : 8'h04);
        applyStimulus(1'b0, 0, 1, 1, 0, 8'h00); stepCycle(1);

        // A: reset while running at 47 with an (invalid) load pending.
        applyStimulus(1'b0, 1, 0, 1, 1, 8'h46); stepCycle(1);
        checkOutput("A load46+start", cntA(), 8'h46);
        applyStimulus(1'b0, 0, 0, 1, 0, 8'h00); stepCycle(1);
        checkOutput("A 47", cntA(), 8'h47);
        rst_n = 1'b0;
        applyStimulus(1'b0, 0, 0, 1, 1, 8'hAA); stepCycle(1);
        checkOutput("A run reset count", cntA(), 8'h00);
        checkOutput("A run reset flags", flagsA(), 8'h00);
        rst_n = 1'b1;
        applyStimulus(1'b0, 0, 0, 1, 0, 8'h00); stepCycle(1);
        checkOutput("A after reset", flagsA(), 8'h00);
        checkOutput("A after reset count", cntA(), 8'h00);

        // B (MODULO=60): rejected and accepted loads.
        applyStimulus(1'b1, 0, 0, 1, 1, 8'h1A); stepCycle(1);
        checkOutput("B load 1A err", flagsB(), 8'h01);
        checkOutput("B load 1A count", cntB(), 8'h00);
        applyStimulus(1'b1, 0, 0, 1, 1, 8'hA1); stepCycle(1);
        checkOutput("B load A1 err", flagsB(), 8'h01);
        applyStimulus(1'b1, 0, 0, 1, 1, 8'h75); stepCycle(1);
        checkOutput("B load 75 err", flagsB(), 8'h01);
        applyStimulus(1'b1, 0, 0, 1, 1, 8'h60); stepCycle(1);
        checkOutput("B load 60 err", flagsB(), 8'h01);
        checkOutput("B rejected count", cntB(), 8'h00);
        applyStimulus(1'b1, 0, 0, 1, 1, 8'h42); stepCycle(1);
        checkOutput("B load 42 count", cntB(), 8'h42);
        checkOutput("B load 42 flags", flagsB(), 8'h00);
        applyStimulus(1'b1, 0, 0, 1, 1, 8'h59); stepCycle(1);
        checkOutput("B load 59", cntB(), 8'h59);

        // B: DIV=4 prescaler and the 59 -> 00 wrap.
        applyStimulus(1'b1, 1, 0, 1, 0, 8'h00); stepCycle(1);
        checkOutput("B start flags", flagsB(), 8'h04);
        applyStimulus(1'b1, 0, 0, 1, 0, 8'h00); stepCycle(3);
        checkOutput("B no early tick", cntB(), 8'h59);
        checkOutput("B no early wrap", flagsB(), 8'h04);
        stepCycle(1);
        checkOutput("B up wrap", cntB(), 8'h00);
        checkOutput("B up wrap flags", flagsB(), 8'h06);
        stepCycle(1);
        checkOutput("B wrap pulse end", flagsB(), 8'h04);
        stepCycle(3);
        checkOutput("B next tick", cntB(), 8'h01);

        // B: load 00 while running, then down (or up in the up-only build).
        applyStimulus(1'b1, 0, 0, 0, 1, 8'h00); stepCycle(1);
        checkOutput("B load00", cntB(), 8'h00);
        applyStimulus(1'b1, 0, 0, 0, 0, 8'h00); stepCycle(3);
        checkOutput("B hold before tick", cntB(), 8'h00);
        stepCycle(1);
        checkOutput("B down tick", cntB(), DOWN_EN ? 8'h59 : 8'h01);
        checkOutput("B down flags", flagsB(), DOWN_EN ? 8'h06 : 8'h04);
        stepCycle(4);
        checkOutput("B second tick", cntB(), DOWN_EN ? 8'h58 : 8'h02);

        // B: start+stop while running, then start alone waits DIV cycles.
        applyStimulus(1'b1, 1, 1, 0, 0, 8'h00); stepCycle(1);
        checkOutput("B both flags", flagsB(), 8'h00);
        applyStimulus(1'b1, 0, 0, 0, 0, 8'h00); stepCycle(5);
        checkOutput("B frozen", cntB(), DOWN_EN ? 8'h58 : 8'h02);
        applyStimulus(1'b1, 1, 0, 0, 0, 8'h00); stepCycle(1);
        checkOutput("B restart flags", flagsB(), 8'h04);
        applyStimulus(1'b1, 0, 0, 0, 0, 8'h00); stepCycle(3);
        checkOutput("B restart wait", cntB(), DOWN_EN ? 8'h58 : 8'h02);
        stepCycle(1);
        checkOutput("B restart tick", cntB(), DOWN_EN ? 8'h57 : 8'h03);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
